// File: rtl/or_reduce_stream_packer.sv
// OR-reduces a packet of WIDTH-bit beats (delimited by in_last) into one
// registered result with a saturating beat count, over valid/ready handshakes.
module or_reduce_stream_packer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_sat
);

    // Handshake: a transfer happens on a rising clk edge where valid && ready.
    // Upstream holds in_valid and payload while in_ready=0; downstream sees a
    // result held stable from out_valid rising until the out_ready cycle.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sat_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [CNT_W-1:0]   out_beats_q;
    logic               out_sat_q;

    logic [WIDTH-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               sat_d;
    logic               beat_acc;

    // One mux per accumulator bit: a set bit stays set, a clear bit takes the beat.
    for (genvar i = 0; i < WIDTH; i++) begin : g_or_mux
        assign acc_d[i] = acc_q[i] ? 1'b1 : in_data[i];
    end

    assign cnt_d    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    // Accepting a beat while already at the ceiling means the true count overflows.
    assign sat_d    = sat_q | (cnt_q == CNT_MAX);
    assign in_ready = (state_q != HOLD);
    assign beat_acc = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat_acc) begin
                        if (in_last) begin
                            out_data_q  <= acc_d;
                            out_beats_q <= cnt_d;
                            out_sat_q   <= sat_d;
                            out_valid_q <= 1'b1;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            sat_q       <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            acc_q       <= acc_d;
                            cnt_q       <= cnt_d;
                            sat_q       <= sat_d;
                            state_q     <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_or_reduce_stream_packer.sv
// Directed bench for or_reduce_stream_packer: a CNT_W=4 and a CNT_W=2 instance
// see the same beat stream and are checked against hand-computed results.
module tb_or_reduce_stream_packer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_beats;
  logic       out_sat;

  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out_data2;
  logic [1:0] out_beats2;
  logic       out_sat2;

  int n_cmp = 0;
  int n_err = 0;

  or_reduce_stream_packer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_sat   (out_sat)
  );

  or_reduce_stream_packer #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2),
    .out_beats (out_beats2),
    .out_sat   (out_sat2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers: inputs change 1ns after the rising edge, outputs read there too
  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic bubble(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h required 00", out_data); end
    n_cmp++; if (out_beats !== 4'd0) begin n_err++; $display("FAIL reset_beats: got %0d required 0", out_beats); end
    n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b required 0", out_sat); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send_beat(8'h01, 1'b0);
    send_beat(8'h10, 1'b0);
    send_beat(8'h80, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b required 1", out_valid); end
    n_cmp++; if (out_data !== 8'h91) begin n_err++; $display("FAIL basic_data: got %h required 91", out_data); end
    n_cmp++; if (out_beats !== 4'd3) begin n_err++; $display("FAIL basic_beats: got %0d required 3", out_beats); end
    n_cmp++; if (out_sat !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %b required 0", out_sat); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b required 1", i, out_valid); end
      n_cmp++; if (out_data !== 8'h91 || out_beats !== 4'd3) begin n_err++; $display("FAIL hold_data[%0d]: got %h/%0d required 91/3", i, out_data, out_beats); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b required 0", i, in_ready); end
    end
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b required 1", in_ready); end
    n_cmp++; if (out_data !== 8'h91) begin n_err++; $display("FAIL release_data_kept: got %h required 91", out_data); end
  endtask

  task automatic test_no_carry();
    send_beat(8'h00, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h00 || out_beats !== 4'd1) begin
      n_err++; $display("FAIL zero_pkt: got %b/%h/%0d required 1/00/1", out_valid, out_data, out_beats); end
    consume();
    send_beat(8'hFF, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_beats !== 4'd1) begin
      n_err++; $display("FAIL ones_pkt: got %b/%h/%0d required 1/ff/1", out_valid, out_data, out_beats); end
    consume();
    send_beat(8'h00, 1'b1);
    n_cmp++; if (out_data !== 8'h00 || out_beats !== 4'd1) begin
      n_err++; $display("FAIL after_ones_pkt: got %h/%0d required 00/1", out_data, out_beats); end
    consume();
  endtask

  task automatic test_bubbles();
    send_beat(8'h01, 1'b0);
    bubble(2);
    send_beat(8'h10, 1'b0);
    bubble(1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_early_valid: got %b required 0", out_valid); end
    send_beat(8'h80, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h91 || out_beats !== 4'd3) begin
      n_err++; $display("FAIL bubble_pkt: got %b/%h/%0d required 1/91/3", out_valid, out_data, out_beats); end
    consume();
  endtask

  task automatic test_saturation();
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h04, 1'b0);
    send_beat(8'h08, 1'b0);
    send_beat(8'h10, 1'b1);
    n_cmp++; if (out_data2 !== 8'h1F) begin n_err++; $display("FAIL sat2_data: got %h required 1f", out_data2); end
    n_cmp++; if (out_beats2 !== 2'd3) begin n_err++; $display("FAIL sat2_beats: got %0d required 3", out_beats2); end
    n_cmp++; if (out_sat2 !== 1'b1) begin n_err++; $display("FAIL sat2_flag: got %b required 1", out_sat2); end
    n_cmp++; if (out_beats !== 4'd5 || out_sat !== 1'b0) begin n_err++; $display("FAIL sat4_beats: got %0d/%b required 5/0", out_beats, out_sat); end
    consume();
    send_beat(8'h40, 1'b1);
    n_cmp++; if (out_sat2 !== 1'b0 || out_beats2 !== 2'd1 || out_data2 !== 8'h40) begin
      n_err++; $display("FAIL sat2_clear: got %b/%0d/%h required 0/1/40", out_sat2, out_beats2, out_data2); end
    consume();
    // exactly 3 beats fills CNT_W=2 without overflowing
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h04, 1'b1);
    n_cmp++; if (out_sat2 !== 1'b0 || out_beats2 !== 2'd3 || out_data2 !== 8'h07) begin
      n_err++; $display("FAIL sat2_edge: got %b/%0d/%h required 0/3/07", out_sat2, out_beats2, out_data2); end
    consume();
  endtask

  task automatic test_reset_midpacket();
    send_beat(8'h0F, 1'b0);
    send_beat(8'hF0, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_err++; $display("FAIL midpkt_reset: got %b/%b/%h required 1/0/00", in_ready, out_valid, out_data); end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    send_beat(8'h02, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h02 || out_beats !== 4'd1) begin
      n_err++; $display("FAIL midpkt_after: got %b/%h/%0d required 1/02/1", out_valid, out_data, out_beats); end
  endtask

  task automatic test_reset_in_hold();
    // previous test left a result pending; reset drops it with no clock edge
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_beats !== 4'd0) begin
      n_err++; $display("FAIL hold_reset: got %b/%h/%0d required 0/00/0", out_valid, out_data, out_beats); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_reset_ready: got %b required 1", in_ready); end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    send_beat(8'hA0, 1'b1);
    consume();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b required 1", in_ready); end
    send_beat(8'h05, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h05 || out_beats !== 4'd1) begin
      n_err++; $display("FAIL b2b_pkt: got %b/%h/%0d required 1/05/1", out_valid, out_data, out_beats); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_no_carry();
    test_bubbles();
    test_saturation();
    test_reset_midpacket();
    test_reset_in_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
